// File: rtl/cmp_pkg.sv
// Shared types for the digit-serial magnitude comparator.
package cmp_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_EQ   = 2'd1,
      RES_GT   = 2'd2,
      RES_LT   = 2'd3
   } res_t;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit digit; no state, no stall.
module cmp_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_chunk,
   input  logic [CHUNK-1:0] b_chunk,
   output logic             chunk_eq,
   output logic             chunk_gt
);

   assign chunk_eq = (a_chunk == b_chunk);
   assign chunk_gt = (a_chunk >  b_chunk);

endmodule

// File: rtl/seq_comparator.sv
// Digit-serial A vs B compare, MSB chunk first; 1..N cycles after start, early exit on first difference.
// enable low freezes everything (adds one cycle per stalled cycle); start is ignored while busy.
module seq_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             greater,
   output logic             lesser
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("seq_comparator: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   res_t             res_q, res_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] msb_flip;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             chunk_eq, chunk_gt;

   // Operands are stored offset-binary in signed mode, so the datapath only ever does unsigned compares.
   assign msb_flip = WIDTH'(signed_mode) << (WIDTH - 1);

   assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_chunk  (a_chunk),
      .b_chunk  (b_chunk),
      .chunk_eq (chunk_eq),
      .chunk_gt (chunk_gt)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      done_d  = 1'b0;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_d     = a ^ msb_flip;
                  b_d     = b ^ msb_flip;
                  idx_d   = IW'(N - 1);
                  state_d = COMPARE;
               end
            end
            COMPARE: begin
               if (!chunk_eq) begin
                  res_d   = chunk_gt ? RES_GT : RES_LT;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (idx_q == '0) begin
                  res_d   = RES_EQ;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= RES_NONE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q == COMPARE);
   assign done    = done_q;
   assign eq      = (res_q == RES_EQ);
   assign greater = (res_q == RES_GT);
   assign lesser  = (res_q == RES_LT);

endmodule

// File: tb/tb_seq_comparator.sv
// Directed table plus corner sequences on the 16/4 comparator; exhaustive/random checks on 8/8 copies.
module tb_seq_comparator;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        start;
   logic [15:0] a, b;
   logic        signed_mode;
   logic        busy, done, eq, greater, lesser;

   logic [7:0]  xa [4];
   logic [7:0]  xb [4];
   logic        xsm, xstart;
   logic        xbusy [4];
   logic        xdone [4];
   logic        xeq [4];
   logic        xgt [4];
   logic        xlt [4];

   int n_vec;
   int n_miss;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .eq          (eq),
      .greater     (greater),
      .lesser      (lesser)
   );

   generate
      for (genvar g = 0; g < 4; g++) begin : g_w8
         seq_comparator #(.WIDTH(8), .CHUNK(8)) u_w8 (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (1'b1),
            .start       (xstart),
            .a           (xa[g]),
            .b           (xb[g]),
            .signed_mode (xsm),
            .busy        (xbusy[g]),
            .done        (xdone[g]),
            .eq          (xeq[g]),
            .greater     (xgt[g]),
            .lesser      (xlt[g])
         );
      end
   endgenerate

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      int          lat;
      logic [2:0]  flg;   // {eq, greater, lesser}
   } vec_t;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; counts negedges until done is seen (or -1 on timeout).
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (done) return;
      end
      lat = -1;
   endtask

   // Called at a negedge; returns latency counted from the accepting edge.
   task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_, input logic sm,
                          output int lat, output logic [2:0] flg);
      a = ta; b = tb_; signed_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 16'(busy), 16'h1);
      wait_done(lat);
      chk("busy_low_at_done", 16'(busy), 16'h0);
      flg = {eq, greater, lesser};
   endtask

   initial begin
      vec_t       tbl [10];
      int         lat, l2;
      logic [2:0] flg;
      logic       saw_done;
      logic [3:0] exp4;

      n_vec = 0; n_miss = 0;
      rst_n = 1'b0; enable = 1'b1; start = 1'b0;
      a = '0; b = '0; signed_mode = 1'b0;
      xsm = 1'b0; xstart = 1'b0;
      for (int i = 0; i < 4; i++) begin xa[i] = '0; xb[i] = '0; end

      tbl[0] = '{16'h1234, 16'h1234, 1'b0, 4, 3'b100};
      tbl[1] = '{16'hF000, 16'h0FFF, 1'b0, 1, 3'b010};
      tbl[2] = '{16'h0005, 16'h0006, 1'b0, 4, 3'b001};
      tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1, 3'b001};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1, 3'b010};
      tbl[5] = '{16'hFFFF, 16'hFFFE, 1'b1, 4, 3'b010};
      tbl[6] = '{16'h1200, 16'h1300, 1'b0, 2, 3'b001};
      tbl[7] = '{16'h7FFF, 16'h8000, 1'b1, 1, 3'b010};
      tbl[8] = '{16'h0000, 16'h0000, 1'b1, 4, 3'b100};
      tbl[9] = '{16'h00A0, 16'h00B0, 1'b0, 3, 3'b001};

      repeat (2) @(negedge clk);
      chk("reset_busy", 16'(busy), 16'h0);
      chk("reset_done", 16'(done), 16'h0);
      chk("reset_flags", 16'({eq, greater, lesser}), 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // A start with enable low must be dropped.
      enable = 1'b0; start = 1'b1; a = 16'h0001; b = 16'h0002;
      @(negedge clk);
      start = 1'b0; enable = 1'b1;
      @(negedge clk);
      chk("start_dropped_when_disabled", 16'(busy), 16'h0);

      for (int i = 0; i < 10; i++) begin
         run_cmp(tbl[i].a, tbl[i].b, tbl[i].sm, lat, flg);
         chk($sformatf("tbl%0d_latency", i), 16'(lat), 16'(tbl[i].lat));
         chk($sformatf("tbl%0d_flags", i), 16'(flg), 16'(tbl[i].flg));
      end

      // Stall for 3 cycles after the second compare cycle; operands change meanwhile.
      a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b0; a = 16'hFFFF; b = 16'h0000;
      repeat (3) @(negedge clk);
      chk("stall_busy_held", 16'(busy), 16'h1);
      chk("stall_no_done", 16'(done), 16'h0);
      enable = 1'b1;
      wait_done(l2);
      chk("stall_latency", 16'(l2 < 0 ? -1 : 5 + l2), 16'd7);
      chk("stall_flags", 16'({eq, greater, lesser}), 16'b001);

      // Start while busy is ignored; operands it carries are not captured.
      a = 16'h0000; b = 16'h0000; start = 1'b1;
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      wait_done(l2);
      chk("busy_start_latency", 16'(l2 < 0 ? -1 : 1 + l2), 16'd4);
      chk("busy_start_flags", 16'({eq, greater, lesser}), 16'b100);
      @(negedge clk);
      chk("no_second_run", 16'(busy), 16'h0);

      // Reset two cycles into a compare aborts it without a done pulse.
      a = 16'h0000; b = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 16'(busy), 16'h0);
      chk("abort_done", 16'(done), 16'h0);
      chk("abort_flags", 16'({eq, greater, lesser}), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done_pulse", 16'(saw_done), 16'h0);
      run_cmp(16'h0003, 16'h0002, 1'b0, lat, flg);
      chk("post_reset_latency", 16'(lat), 16'd4);
      chk("post_reset_flags", 16'(flg), 16'b010);

      // 8-bit single-chunk copies: all pairs unsigned, two cycles per pair.
      @(negedge clk);
      xsm = 1'b0;
      for (int ah = 0; ah < 64; ah++) begin
         for (int bv = 0; bv < 256; bv++) begin
            for (int i = 0; i < 4; i++) begin
               xa[i] = 8'(ah + 64 * i);
               xb[i] = 8'(bv);
            end
            xstart = 1'b1;
            @(negedge clk);
            xstart = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
               exp4 = {1'b1, xa[i] == xb[i], xa[i] > xb[i], xa[i] < xb[i]};
               chk($sformatf("w8u a=%02h b=%02h {done,eq,gt,lt}", xa[i], xb[i]),
                   16'({xdone[i], xeq[i], xgt[i], xlt[i]}), 16'(exp4));
            end
         end
      end

      xsm = 1'b1;
      for (int n = 0; n < 1024; n++) begin
         for (int i = 0; i < 4; i++) begin
            xa[i] = 8'($urandom);
            xb[i] = 8'($urandom);
         end
         xstart = 1'b1;
         @(negedge clk);
         xstart = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            exp4 = {1'b1, xa[i] == xb[i], $signed(xa[i]) > $signed(xb[i]),
                    $signed(xa[i]) < $signed(xb[i])};
            chk($sformatf("w8s a=%02h b=%02h {done,eq,gt,lt}", xa[i], xb[i]),
                16'({xdone[i], xeq[i], xgt[i], xlt[i]}), 16'(exp4));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, digit-serial magnitude comparator that generalises the team's 4-bit combinational comparator (enable in; eq/greater/lesser out) to any operand width. It adds selectable signed or unsigned ordering, a start/busy/done handshake, and early termination on the first differing chunk. It sits in the ALU datapath beside the adder and logic units and serves compare-class opcodes where single-cycle wide compare would limit clock frequency.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK
- CHUNK, 4: bits examined per cycle; N = WIDTH/CHUNK chunks
- clk  in  1  rising-edge clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- enable  in  1  global advance qualifier; low freezes all state
- start  in  1  request a comparison; sampled only in IDLE with enable=1
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- signed_mode  in  1  1 = two's-complement ordering, 0 = unsigned; captured on accepted start
- busy  out  1  high while in COMPARE
- done  out  1  one-cycle pulse when the result registers update
- eq  out  1  A == B
- greater  out  1  A > B
- lesser  out  1  A < B

## Operation
- States: IDLE, COMPARE.
- IDLE:
  - On start=1 and enable=1, capture a, b and signed_mode into internal registers, set idx = N-1, and go to COMPARE.
  - A start with enable=0 is dropped.
- COMPARE, per cycle with enable=1:
  - Compare chunk idx of captured A against chunk idx of captured B, MSB chunk first.
  - Signed mode: invert the top bit of both operands (offset-binary) before comparing. This affects chunk N-1 only.
  - Chunks differ: load greater/lesser accordingly, eq=0, pulse done, go to IDLE.
  - Chunks equal and idx==0: load eq=1, greater=0, lesser=0, pulse done, go to IDLE.
  - Otherwise idx decrements.
- COMPARE with enable=0: idx, state and captured operands hold; done stays 0.
- start while busy is ignored. Captured operands are not disturbed by input changes.
- eq/greater/lesser hold their last result until the next completion. After any completion exactly one of the three is high.
- Reset (any time, including mid-COMPARE):
  - State goes to IDLE, idx = 0, captured registers cleared.
  - busy = 0, done = 0, eq = greater = lesser = 0.
  - No done pulse is produced for the aborted comparison.

## Timing
- Accepted start at edge T0: busy=1 from T0.
- Decision on chunk k (k = number of chunks examined, 1..N):
  - done=1 and flags valid in the cycle after edge T0+k, given no stalls.
  - Each enable-low cycle in COMPARE adds one cycle of latency.
- Latency bounds: minimum 1 cycle (MSB chunk differs), maximum N cycles (equal operands or difference only in chunk 0).
- busy falls on the same edge that raises done.
- Back-to-back operation: the earliest next start is accepted on the edge after done. There is no zero-bubble restart.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package cmp_pkg:
  - state enum typedef {IDLE, COMPARE}
  - result typedef {RES_NONE, RES_EQ, RES_GT, RES_LT}, decoded to the three flags at the output registers
- Sub-module cmp_chunk: combinational CHUNK-bit unsigned compare returning chunk_eq and chunk_gt. It is instantiated once and driven by a mux on idx.
- Elaboration-time check that WIDTH % CHUNK == 0 and CHUNK >= 1.

## Test plan
- WIDTH=16, CHUNK=4, unsigned, a=0x1234, b=0x1234: done 4 cycles after start, eq=1, greater=0, lesser=0.
- Unsigned a=0xF000, b=0x0FFF: done 1 cycle after start, greater=1. Then a=0x0005, b=0x0006: done after 4 cycles, lesser=1.
- a=0x8000, b=0x0001:
  - signed_mode=1: done after 1 cycle, lesser=1.
  - Repeat with signed_mode=0: greater=1.
  - Signed a=0xFFFF, b=0xFFFE: greater=1 after 4 cycles.
- Unsigned a=0x0001, b=0x0002, enable low for 3 cycles after the second compare cycle: done 7 cycles after start, lesser=1, operands changed during stall do not affect the result.
- Mid-operation events on a=0x0000, b=0x0000:
  - A start pulse issued while busy is ignored.
  - rst_n asserted 2 cycles in: busy=0, flags=000, no done pulse.
  - A new start after reset completes normally.
- WIDTH=8, CHUNK=8: every comparison completes in 1 cycle. Check all 256×256 operands in unsigned mode and a random 4096-pair sample in signed mode against a reference model.
